// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
package uart_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  localparam logic [7:0] DEF_END_BYTE = 8'h0A;
  localparam int         MAX_REQ      = 8;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin winner search starting at rr_ptr and wrapping modulo NUM_REQ.
// With UART_ARB_PRIO_EN defined, requester 0 wins whenever it is requesting.
module uart_rr_picker import uart_arb_pkg::*; #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      winner,
  output logic               found
);

  // Two passes: indices at/above rr_ptr first, then the wrapped-around ones.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req[i] && i >= int'(rr_ptr)) begin
        found  = 1'b1;
        winner = IW'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req[i] && i < int'(rr_ptr)) begin
        found  = 1'b1;
        winner = IW'(i);
      end
`ifdef UART_ARB_PRIO_EN
    if (req[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART TX byte stream.
// Optional UART_ARB_PRIO_EN: requester 0 wins every idle arbitration it joins.
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int         NUM_REQ  = 2,
  parameter int         MAX_HOLD = 64,
  parameter int         IDLE_TO  = 16,
  parameter logic [7:0] END_BYTE = DEF_END_BYTE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_HOLD+1);
  localparam int TW = $clog2(IDLE_TO+1);

  arb_state_e         state, state_d;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IW-1:0]      g_idx, rr_ptr, winner;
  logic               found;
  logic [BW-1:0]      byte_cnt;
  logic [TW-1:0]      idle_cnt;
  logic               g_valid, xfer, rel;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .found  (found)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (found) state_d = GRANT;
      GRANT: if (rel)   state_d = IDLE;
    endcase
  end

  // Combinational data path from the granted requester; rst blanks it so
  // nothing transfers in the reset cycle.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    g_valid   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (state == GRANT && g_idx == IW'(i)) begin
        g_valid = req_valid[i];
        if (!rst) begin
          tx_valid     = req_valid[i];
          tx_data      = req_data[i*8 +: 8];
          req_ready[i] = tx_ready;
        end
      end
  end

  assign gnt  = rst ? '0 : gnt_q;
  assign busy = (state == GRANT) && !rst;

  assign xfer = tx_valid && tx_ready;
  assign rel  = (state == GRANT) &&
                ((xfer && tx_data == END_BYTE) ||
                 (xfer && byte_cnt == BW'(MAX_HOLD-1)) ||
                 (!g_valid && idle_cnt == TW'(IDLE_TO-1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= '0;
      g_idx    <= '0;
      rr_ptr   <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else if (state == IDLE) begin
      byte_cnt <= '0;
      idle_cnt <= '0;
      if (found) begin
        gnt_q <= NUM_REQ'(onehot(3'(winner)));
        g_idx <= winner;
      end
    end else if (rel) begin
      gnt_q    <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      rr_ptr   <= (g_idx == IW'(NUM_REQ-1)) ? '0 : g_idx + IW'(1);
    end else if (xfer) begin
      byte_cnt <= byte_cnt + BW'(1);
      idle_cnt <= '0;
    end else if (!g_valid) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected {gnt,byte} pairs are queued
// at stimulus time and popped by a monitor on every tx handshake.
module tb_uart_tx_arbiter;
  logic        clk, rst, tx_ready, tx_valid, busy;
  logic [1:0]  req_valid, req_ready, gnt;
  logic [15:0] req_data;
  logic [7:0]  tx_data;

  logic [7:0]  rq0 [$];
  logic [7:0]  rq1 [$];
  logic [9:0]  exp_q [$];
  logic [1:0]  hs;
  int          checks = 0, failures = 0;
  int          t2_tbl [13];

  uart_tx_arbiter #(.NUM_REQ(2), .MAX_HOLD(4), .IDLE_TO(16), .END_BYTE(8'h0A)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .gnt(gnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic pushx(input logic [1:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    smp();
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin smp(); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d transfers still outstanding, required 0", nm, exp_q.size());
      exp_q.delete(); rq0.delete(); rq1.delete();
    end
  endtask

  // Requester models: present queue head, pop after a handshake.
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (hs[0] && rq0.size() > 0) rq0.delete(0);
      if (hs[1] && rq1.size() > 0) rq1.delete(0);
      req_valid[0]    = rq0.size() > 0;
      req_data[7:0]   = (rq0.size() > 0) ? rq0[0] : 8'h00;
      req_valid[1]    = rq1.size() > 0;
      req_data[15:8]  = (rq1.size() > 0) ? rq1[0] : 8'h00;
    end
  end

  // Monitor: every handshake must match the next expected {gnt,byte}.
  initial begin
    logic [9:0] e;
    hs = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL xfer_unexpected: got gnt=%b data=%h, required no transfer", gnt, tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_gnt_data", {22'd0, gnt, tx_data}, {22'd0, e});
        end
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tx_ready = 1'b1;
    // Reset state and first cycle after reset
    smp();
    chk("rst_tx_valid", tx_valid, 0); chk("rst_gnt", gnt, 0); chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0); chk("rst_tx_data", tx_data, 0);
    step(); rst = 1'b0;
    smp();
    chk("post_rst_tx_valid", tx_valid, 0); chk("post_rst_gnt", gnt, 0);

    // T1: single message from req0
    step();
    rq0 = '{8'h41, 8'h42, 8'h0A};
    pushx(2'b01, 8'h41); pushx(2'b01, 8'h42); pushx(2'b01, 8'h0A);
    smp(); smp(); chk("t1_gnt_before_latency", gnt, 0);
    smp(); chk("t1_gnt_rise", gnt, 2'b01); chk("t1_first_byte_valid", tx_valid, 1);
    smp(); chk("t1_consec2", tx_valid, 1);
    smp(); chk("t1_consec3", tx_data, 8'h0A);
    smp(); chk("t1_idle_gnt", gnt, 0); chk("t1_idle_busy", busy, 0);

    // T6: rr_ptr=1 after T1, both requesting in IDLE
    rq0 = '{8'h30, 8'h0A}; rq1 = '{8'h31, 8'h0A};
`ifdef UART_ARB_PRIO_EN
    pushx(2'b01, 8'h30); pushx(2'b01, 8'h0A); pushx(2'b10, 8'h31); pushx(2'b10, 8'h0A);
`else
    pushx(2'b10, 8'h31); pushx(2'b10, 8'h0A); pushx(2'b01, 8'h30); pushx(2'b01, 8'h0A);
`endif
    smp(); chk("t6_idle", gnt, 0);
`ifdef UART_ARB_PRIO_EN
    smp(); chk("t6_winner", gnt, 2'b01);
`else
    smp(); chk("t6_winner", gnt, 2'b10);
`endif
    wait_drain("t6", 40);

    // T2: both continuously valid, two "X\n" messages each
    do_reset();
`ifdef UART_ARB_PRIO_EN
    t2_tbl = '{0, 1, 1, 0, 1, 1, 0, 2, 2, 0, 2, 2, 0};
    pushx(1, 8'h58); pushx(1, 8'h0A); pushx(1, 8'h58); pushx(1, 8'h0A);
    pushx(2, 8'h58); pushx(2, 8'h0A); pushx(2, 8'h58); pushx(2, 8'h0A);
`else
    t2_tbl = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
    pushx(1, 8'h58); pushx(1, 8'h0A); pushx(2, 8'h58); pushx(2, 8'h0A);
    pushx(1, 8'h58); pushx(1, 8'h0A); pushx(2, 8'h58); pushx(2, 8'h0A);
`endif
    rq0 = '{8'h58, 8'h0A, 8'h58, 8'h0A}; rq1 = '{8'h58, 8'h0A, 8'h58, 8'h0A};
    for (int k = 0; k < 13; k++) begin
      smp(); chk($sformatf("t2_gnt_c%0d", k), gnt, t2_tbl[k]);
    end
    wait_drain("t2", 20);

    // T3: MAX_HOLD=4 forced release, req0 gets the next grant
    do_reset();
    rq1 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
    for (int k = 0; k < 4; k++) pushx(2, 8'hA0 + 8'(k));
    pushx(1, 8'hB0); pushx(1, 8'h0A);
    for (int k = 4; k < 10; k++) pushx(2, 8'hA0 + 8'(k));
    smp();
    rq0 = '{8'hB0, 8'h0A};
    smp(); chk("t3_gnt_req1", gnt, 2'b10);
    smp(); smp();
    smp(); chk("t3_hold_4th", gnt, 2'b10);
    smp(); chk("t3_release_max", gnt, 0);
    smp(); chk("t3_req0_next", gnt, 2'b01);
    wait_drain("t3", 60);

    // T4: idle timeout, then a long stall that must not release
    do_reset();
    rq0 = '{8'hC0}; pushx(1, 8'hC0);
    smp(); smp(); chk("t4_gnt", gnt, 2'b01);
    for (int k = 2; k < 18; k++) smp();
    chk("t4_hold_idle15", gnt, 2'b01);
    smp(); chk("t4_idle_release", gnt, 0);
    tx_ready = 1'b0;
    rq0 = '{8'hC1, 8'h0A}; pushx(1, 8'hC1); pushx(1, 8'h0A);
    smp();
    for (int k = 0; k < 20; k++) smp();
    chk("t4_stall_gnt", gnt, 2'b01); chk("t4_stall_valid", tx_valid, 1);
    step(); tx_ready = 1'b1;
    wait_drain("t4", 20);

    // T5: reset mid-message after 2 of 5 bytes
    smp();
    rq0 = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'h0A};
    pushx(1, 8'hD0); pushx(1, 8'hD1); pushx(1, 8'hD2); pushx(1, 8'hD3); pushx(1, 8'h0A);
    pushx(2, 8'h5A); pushx(2, 8'h0A);
    smp(); smp(); chk("t5_gnt", gnt, 2'b01);
    smp();
    step(); rst = 1'b1; rq1 = '{8'h5A, 8'h0A};
    smp(); chk("t5_rst_tx_valid", tx_valid, 0); chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_req_ready", req_ready, 0);
    step(); rst = 1'b0;
    smp(); chk("t5_after_tx_valid", tx_valid, 0); chk("t5_after_gnt", gnt, 0);
    smp(); chk("t5_rearb_req0", gnt, 2'b01);
    wait_drain("t5", 40);

    smp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmit byte stream (tx_valid/tx_ready/tx_data) between NUM_REQ byte-stream requesters, for example the AHB-to-UART bridge print path and a debug/trace source. It grants one requester at a time in round-robin order. The grant is held for a whole message: it ends on a terminator byte, a byte limit, or an idle timeout, so messages never interleave. It sits between the requesters and the UART TX serializer.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_HOLD, 64, maximum bytes transferred per grant before forced release (>=1)
IDLE_TO, 16, cycles a granted requester may hold valid low before forced release (>=1)
END_BYTE, 8'h0A, terminator byte that ends a message

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [i*8 +: 8]
req_ready  output  NUM_REQ  per-requester byte accepted
tx_valid  output  1  byte valid to UART TX
tx_data  output  8  byte to UART TX
tx_ready  input  1  UART TX can accept a byte
gnt  output  NUM_REQ  one-hot current grant; all zero when idle
busy  output  1  a grant is active

Behaviour:
- Single clock. Reset is synchronous and active-high. On rst: state=IDLE, rr_ptr=0, gnt=0, byte_cnt=0, idle_cnt=0.
- Outputs with rst asserted and in the first cycle after it: tx_valid=0, req_ready=0, gnt=0, busy=0, tx_data=0.
- State IDLE:
  - tx_valid=0, req_ready=0, tx_data=0.
  - If any req_valid is set, pick the winner: the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register gnt=onehot(winner) and move to GRANT on the next edge.
  - Grant latency: 1 cycle from req_valid to gnt; the first byte can transfer in the cycle gnt rises.
- State GRANT, with g = granted index. The data path is combinational, with no added latency:
  - tx_valid = req_valid[g]
  - tx_data = req_data[g]
  - req_ready[g] = tx_ready
  - all other req_ready = 0
- A transfer is tx_valid && tx_ready. On each transfer: byte_cnt += 1 and idle_cnt clears.
- In a cycle with req_valid[g]=0: idle_cnt += 1. A stall (tx_valid=1, tx_ready=0) neither increments nor clears idle_cnt.
- Release conditions (evaluated on the edge ending a cycle):
  - a transfer whose tx_data==END_BYTE
  - a transfer that makes byte_cnt==MAX_HOLD
  - idle_cnt reaching IDLE_TO
- On release:
  - state goes to IDLE; gnt, byte_cnt and idle_cnt clear
  - rr_ptr = (g+1) mod NUM_REQ
  - there is at least one bubble cycle between grants
- If END_BYTE and the MAX_HOLD limit coincide on one transfer, there is a single release; rr_ptr is updated once.
- No preemption: a requester raising req_valid during another requester's grant waits for release.
- Width rules:
  - index and rr_ptr are $clog2(NUM_REQ) bits, with explicit wrap logic when NUM_REQ is not a power of 2
  - byte_cnt is $clog2(MAX_HOLD+1) bits
  - idle_cnt is $clog2(IDLE_TO+1) bits
  - counters never wrap, because release clears them
- Requesters must hold req_data stable while req_valid=1 and req_ready=0. The arbiter does not check this.
- rst mid-message: the grant is dropped immediately. No byte transfers in the reset cycle. The remaining bytes are re-arbitrated as a new message after reset.

Optional Feature:
UART_ARB_PRIO_EN:
- Defined: requester 0 is urgent. In IDLE, if req_valid[0]=1 it wins regardless of rr_ptr. It still cannot preempt an active grant. rr_ptr update on release is unchanged.
- Undefined: pure round-robin as above.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, GRANT, 1-bit logic), default END_BYTE constant, onehot helper function.
- One sub-module, uart_rr_picker: combinational. Inputs are the request vector and rr_ptr. Outputs are winner index and found flag. Parameterised by NUM_REQ. The PRIO override is applied inside it under the macro.

Test Plan:
1. NUM_REQ=2. req0 sends 8'h41, 8'h42, 8'h0A with tx_ready=1. Required response: gnt=2'b01 one cycle after req_valid; three transfers on consecutive cycles; IDLE after the 0x0A; rr_ptr=1.
2. req0 and req1 both valid continuously, each sending "X\n". Required response: grant order req0, req1, req0, req1; bytes never interleave; one bubble cycle between grants.
3. MAX_HOLD=4. req1 streams 10 bytes with no 0x0A. Required response: release after the 4th transfer; req0 (waiting) is granted next; req1 resumes on a later grant.
4. IDLE_TO=16. req0 is granted, sends 1 byte, then drops valid. Required response: release on the 16th idle cycle; a tx_ready=0 stall with valid=1 lasting 20 cycles does not release.
5. rst asserted mid-message after 2 of 5 bytes. Required response: tx_valid=0 and gnt=0 in the reset cycle and the following cycle; rr_ptr=0; re-arbitration afterwards.
6. With UART_ARB_PRIO_EN, rr_ptr=1, and req0 and req1 valid in IDLE. Required response: req0 wins. Without the macro: req1 wins.
